shreg_load_ctrl: RTL and testbench

- Sequencer that loads a parallel word into a downstream serial-in, parallel-out shift chain built from DFF stages with a shared shift enable.
- Accepts a word via a START/READY handshake and presents it serially on SDO.
- Emits one SHIFT_EN strobe per bit and a LATCH strobe after the last bit.
- Sits between register-file/control logic and the display/output shift chains.

---
 rtl/shreg_ctrl_pkg.sv | 24 ++
 rtl/bit_tick_gen.sv | 43 ++++
 rtl/shreg_load_ctrl.sv | 137 +++++++++++++
 tb/tb_shreg_load_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shreg_ctrl_pkg.sv
// Shared definitions for the shift-chain load sequencer: FSM state encoding
// and a constant-evaluable ceiling-log2 used to size counters.
package shreg_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  // Bits needed to hold the values 0..n-1; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period prescaler: counts 0..DIV-1 while enabled, TICK marks the last
// cycle of a period, TICK_NEXT predicts TICK one cycle ahead.
module bit_tick_gen
  import shreg_ctrl_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic CLK,
  input  logic CLR,
  input  logic CLEAR,
  input  logic ENABLE,
  output logic TICK,
  output logic TICK_NEXT
);

  localparam int CW = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count;
    if (CLEAR) begin
      count_next = '0;
    end else if (ENABLE) begin
      count_next = (count == LAST) ? '0 : count + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign TICK      = (count == LAST);
  // Lets the controller register SHIFT_EN so it rises in the tick cycle itself.
  assign TICK_NEXT = (count_next == LAST);

endmodule

// File: rtl/shreg_load_ctrl.sv
// Loads a parallel word serially into a DFF shift chain: SDO + SHIFT_EN per bit,
// then LATCH/DONE. Define SHREG_LOAD_CTRL_MSB_FIRST_EN to send MSB first.
module shreg_load_ctrl
  import shreg_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] DIN,
  output logic             READY,
  output logic             BUSY,
  output logic             SDO,
  output logic             SHIFT_EN,
  output logic             LATCH,
  output logic             DONE,
  output logic [1:0]       STATE_DBG
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [CW-1:0]    bit_cnt;
  logic             tick;
  logic             tick_next;
  logic             pre_clear;
  logic             pre_enable;
  logic [WIDTH-1:0] load_rest;
  logic             load_lead;
  logic [WIDTH-1:0] shift_rest;
  logic             shift_lead;

  // The shadow holds only the bits not yet on SDO; SDO itself is the register
  // carrying the bit of the current period.
`ifdef SHREG_LOAD_CTRL_MSB_FIRST_EN
  assign load_lead  = DIN[WIDTH-1];
  assign load_rest  = {DIN[WIDTH-2:0], 1'b0};
  assign shift_lead = shadow[WIDTH-1];
  assign shift_rest = {shadow[WIDTH-2:0], 1'b0};
`else
  assign load_lead  = DIN[0];
  assign load_rest  = {1'b0, DIN[WIDTH-1:1]};
  assign shift_lead = shadow[0];
  assign shift_rest = {1'b0, shadow[WIDTH-1:1]};
`endif

  assign pre_clear  = (state != S_SHIFT) || ABORT;
  assign pre_enable = (state == S_SHIFT);

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .CLK       (CLK),
    .CLR       (CLR),
    .CLEAR     (pre_clear),
    .ENABLE    (pre_enable),
    .TICK      (tick),
    .TICK_NEXT (tick_next)
  );

  // Handshake: START is taken on a rising edge where READY=1 and ABORT=0;
  // while BUSY, START is ignored and nothing is queued.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state    <= S_IDLE;
      shadow   <= '0;
      bit_cnt  <= '0;
      SDO      <= 1'b0;
      SHIFT_EN <= 1'b0;
      LATCH    <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          LATCH <= 1'b0;
          DONE  <= 1'b0;
          if (START && !ABORT) begin
            state    <= S_SHIFT;
            shadow   <= load_rest;
            bit_cnt  <= '0;
            SDO      <= load_lead;
            SHIFT_EN <= tick_next;
          end else begin
            SDO      <= 1'b0;
            SHIFT_EN <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (ABORT) begin
            state    <= S_IDLE;
            SDO      <= 1'b0;
            SHIFT_EN <= 1'b0;
            LATCH    <= 1'b0;
            DONE     <= 1'b0;
          end else if (tick) begin
            shadow  <= shift_rest;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) begin
              state    <= S_LATCH;
              SDO      <= 1'b0;
              SHIFT_EN <= 1'b0;
              LATCH    <= 1'b1;
              DONE     <= 1'b1;
            end else begin
              SDO      <= shift_lead;
              SHIFT_EN <= tick_next;
            end
          end else begin
            SHIFT_EN <= tick_next;
          end
        end
        S_LATCH: begin
          state    <= S_IDLE;
          SDO      <= 1'b0;
          SHIFT_EN <= 1'b0;
          LATCH    <= 1'b0;
          DONE     <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          SDO      <= 1'b0;
          SHIFT_EN <= 1'b0;
          LATCH    <= 1'b0;
          DONE     <= 1'b0;
        end
      endcase
    end
  end

  assign READY     = (state == S_IDLE);
  assign BUSY      = !READY;
  assign STATE_DBG = state;

endmodule

// File: tb/tb_shreg_load_ctrl.sv
// Bench for shreg_load_ctrl: one DIV=1 and one DIV=3 instance checked every
// cycle against a transfer-timeline model plus a model of the downstream chain.
module tb_shreg_load_ctrl;

  localparam int W     = 4;
  localparam int DIV_A = 1;
  localparam int DIV_B = 3;

  logic         clk;
  logic         clr;
  logic [1:0]   start;
  logic [1:0]   abort;
  logic [W-1:0] din [2];
  logic [1:0]   ready;
  logic [1:0]   busy;
  logic [1:0]   sdo;
  logic [1:0]   shift_en;
  logic [1:0]   latch;
  logic [1:0]   done;
  logic [1:0]   state_dbg [2];

  int n_checks;
  int n_errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  shreg_load_ctrl #(.WIDTH(W), .DIV(DIV_A)) u_dut_a (
    .CLK(clk), .CLR(clr), .START(start[0]), .ABORT(abort[0]), .DIN(din[0]),
    .READY(ready[0]), .BUSY(busy[0]), .SDO(sdo[0]), .SHIFT_EN(shift_en[0]),
    .LATCH(latch[0]), .DONE(done[0]), .STATE_DBG(state_dbg[0])
  );

  shreg_load_ctrl #(.WIDTH(W), .DIV(DIV_B)) u_dut_b (
    .CLK(clk), .CLR(clr), .START(start[1]), .ABORT(abort[1]), .DIN(din[1]),
    .READY(ready[1]), .BUSY(busy[1]), .SDO(sdo[1]), .SHIFT_EN(shift_en[1]),
    .LATCH(latch[1]), .DONE(done[1]), .STATE_DBG(state_dbg[1])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d @%0t got=%0h exp=%0h", tag, inst, $time, got, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic logic [W-1:0] chain_word(input logic [W-1:0] w);
    logic [W-1:0] r;
`ifdef SHREG_LOAD_CTRL_MSB_FIRST_EN
    for (int b = 0; b < W; b++) r[b] = w[W-1-b];
`else
    r = w;
`endif
    return r;
  endfunction

  function automatic logic word_bit(input logic [W-1:0] w, input int k);
`ifdef SHREG_LOAD_CTRL_MSB_FIRST_EN
    return w[W-1-k];
`else
    return w[k];
`endif
  endfunction

  // ---------------- reference model ----------------
  // m_c is the cycle index since the accepting edge (1 = first cycle after it).
  bit           m_busy [2];
  int           m_c [2];
  logic [W-1:0] m_din [2];
  int           m_latches [2];
  logic [W-1:0] chain_q [2];
  int           dut_latches [2];

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0;
        m_c[i]    = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        // Downstream chain: first bit shifted in walks down to Q[0].
        if (shift_en[i]) chain_q[i] = {sdo[i], chain_q[i][W-1:1]};
        if (!m_busy[i]) begin
          if (start[i] && !abort[i]) begin
            m_busy[i] = 1'b1;
            m_c[i]    = 1;
            m_din[i]  = din[i];
          end
        end else if (abort[i] || m_c[i] == W * div_of(i) + 1) begin
          m_busy[i] = 1'b0;
        end else begin
          m_c[i] = m_c[i] + 1;
          if (m_c[i] == W * div_of(i) + 1) m_latches[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 2; i++) begin
        int d;
        int last;
        logic e_se;
        logic e_l;
        d    = div_of(i);
        last = W * d;
        e_se = m_busy[i] && (m_c[i] <= last) && (m_c[i] % d == 0);
        e_l  = m_busy[i] && (m_c[i] == last + 1);
        if (latch[i]) dut_latches[i]++;
        check("ready", i, 32'(ready[i]), 32'(!m_busy[i]));
        check("busy", i, 32'(busy[i]), 32'(m_busy[i]));
        check("shift_en", i, 32'(shift_en[i]), 32'(e_se));
        check("latch", i, 32'(latch[i]), 32'(e_l));
        check("done", i, 32'(done[i]), 32'(e_l));
        if (m_busy[i] && m_c[i] <= last)
          check("sdo", i, 32'(sdo[i]), 32'(word_bit(m_din[i], (m_c[i] - 1) / d)));
        if (e_l) check("chain_q", i, 32'(chain_q[i]), 32'(chain_word(m_din[i])));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_ready"}, i, 32'(ready[i]), 32'd1);
      check({tag, "_busy"}, i, 32'(busy[i]), 32'd0);
      check({tag, "_sdo"}, i, 32'(sdo[i]), 32'd0);
      check({tag, "_shift_en"}, i, 32'(shift_en[i]), 32'd0);
      check({tag, "_latch"}, i, 32'(latch[i]), 32'd0);
      check({tag, "_done"}, i, 32'(done[i]), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] s1_word;
    logic [W-1:0] s2_word;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 2; i++) begin
      m_latches[i]   = 0;
      dut_latches[i] = 0;
      chain_q[i]     = '0;
      m_din[i]       = '0;
      din[i]         = '0;
    end
    clr   = 1'b0;
    start = 2'b00;
    abort = 2'b00;
    #3;
    check_reset_outputs("reset");
    cycles(2);
    clr = 1'b1;

    // Scenarios 1-3: DIN=1011 on DIV=1, DIN=0110 on DIV=3, extra STARTs while busy.
    s1_word = 4'b1011;
    s2_word = 4'b0110;
    cycles(1);
    din[0] = s1_word; start[0] = 1'b1;
    din[1] = s2_word; start[1] = 1'b1;
    cycles(1);
    start = 2'b00;
    din[0] = W'($urandom); din[1] = W'($urandom);
    cycles(1);
    start[0] = 1'b1; din[0] = 4'b0101;
    cycles(1);
    start[0] = 1'b0;
    cycles(1);
    start[0] = 1'b1; din[0] = 4'b1110;
    cycles(1);
    start[0] = 1'b0;
    cycles(10);
    check("s1_chain", 0, 32'(chain_q[0]), 32'(chain_word(s1_word)));
    check("s2_chain", 1, 32'(chain_q[1]), 32'(chain_word(s2_word)));
    check("s3_latch_count", 0, 32'(dut_latches[0]), 32'd1);

    // Scenario 4: ABORT in cycle 2, then a clean transfer.
    cycles(1);
    start[0] = 1'b1; din[0] = W'($urandom);
    cycles(1);
    start[0] = 1'b0;
    cycles(1);
    abort[0] = 1'b1;
    cycles(1);
    abort[0] = 1'b0;
    check("s4_ready_after_abort", 0, 32'(ready[0]), 32'd1);
    start[0] = 1'b1; din[0] = 4'b1001;
    cycles(1);
    start[0] = 1'b0;
    cycles(8);
    check("s4_chain", 0, 32'(chain_q[0]), 32'(chain_word(4'b1001)));

    // Scenario 5: asynchronous reset in cycle 5 of a DIV=3 transfer.
    start[1] = 1'b1; din[1] = W'($urandom);
    cycles(1);
    start[1] = 1'b0;
    cycles(3);
    @(posedge clk);
    #2 clr = 1'b0;
    #1 check_reset_outputs("async_clr");
    cycles(1);
    clr = 1'b1;
    cycles(1);
    start = 2'b11; din[0] = 4'b0011; din[1] = 4'b1100;
    cycles(1);
    start = 2'b00;
    cycles(16);
    check("s5_chain", 1, 32'(chain_q[1]), 32'(chain_word(4'b1100)));

    // Randomized traffic with occasional aborts and START while busy.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom_range(0, 3) == 0);
        abort[i] = ($urandom_range(0, 39) == 0);
        din[i]   = W'($urandom);
      end
      cycles(1);
    end
    start = 2'b00;
    abort = 2'b00;
    cycles(20);
    for (int i = 0; i < 2; i++)
      check("latch_total", i, 32'(dut_latches[i]), 32'(m_latches[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
